addsub_sequencer: RTL and testbench
===================================

Name: addsub_sequencer

Overview:
- Multicycle control unit directly upstream of the add/subtract datapath.
- Generates the datapath controls `s0`, `s1`, `s2`, `addOrSub` and `done` that evaluate `A ± B ± C ± D`. Arithmetic is 8-bit and wraps mod 256.
- Takes one start pulse plus a per-term operation and enable word, steps the datapath one term per phase, then captures the accumulator into a result register with a one-cycle valid pulse.

Parameters:
- SETTLE, default 1: clock cycles each phase (LOAD and every term) is held. Legal values are 1..15.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled on a rising edge only while idle.
- op_sub  in  3  per-term op, bit0=B, bit1=C, bit2=D; 1=subtract, 0=add.
- term_en  in  3  per-term enable, same bit mapping; 0 = skip term.
- acc_in  in  8  datapath accumulator (the register output feeding the adder).
- busy  out  1  high from the start-accept edge until the edge leaving CAPTURE.
- s0  out  1  register-source select; 0 = load A, 1 = load adder output.
- s1  out  1  operand select low bit.
- s2  out  1  operand select high bit; {s2,s1}: 00=B, 01=C, 10=D. 11 is never driven.
- addOrSub  out  1  1=add, 0=subtract.
- done  out  1  1 = datapath arithmetic frozen; 0 = datapath may compute.
- result  out  8  captured result, held until the next capture or reset.
- result_valid  out  1  one-cycle pulse when result updates.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, busy=0, s0=0, {s2,s1}=00, addOrSub=1, done=1, result=0, result_valid=0.
  - Latched op/enable cleared; phase counter cleared.
  - Reset asserted mid-operation aborts it; no result_valid pulse.
- All outputs are registered (Moore); no combinational path from inputs to outputs.
- States: IDLE, LOAD, TERM, CAPTURE.
- IDLE:
  - Outputs: s0=0, {s2,s1}=00, addOrSub=1, done=1, busy=0.
  - start=1 at an edge: latch op_sub and term_en, then go to LOAD.
- LOAD:
  - Outputs: s0=0, done=1, busy=1; held SETTLE cycles (datapath register takes A).
  - On exit, go to TERM for the lowest-index enabled term. If term_en latched == 000, go to CAPTURE.
- TERM(k):
  - Outputs: s0=1, done=0, {s2,s1}=k encoding, addOrSub=~op_sub[k]; held SETTLE cycles.
  - On exit, go to the next higher enabled term, else CAPTURE.
  - Consecutive TERM phases always differ in {s2,s1}, so the datapath re-evaluates each term exactly once.
- CAPTURE:
  - Outputs: done=1, s0=1, select and addOrSub held from the last term; lasts one cycle.
  - On the exit edge: result<=acc_in, result_valid<=1, busy<=0, state<=IDLE.
- result_valid is high exactly one cycle (the first IDLE cycle), then returns to 0.
- Latency: with N enabled terms, result_valid rises SETTLE*(1+N)+1 edges after the edge that accepted start.
  - SETTLE=1, N=3: 5 edges. N=0: SETTLE+1 edges.
- start while busy=1: ignored, not queued.
- op_sub/term_en changes while busy: ignored (latched copies are used).
- start=1 in the result_valid cycle: accepted. The new run's LOAD begins next cycle and the result_valid pulse still completes.
- start held continuously: back-to-back runs, one per latency period.
- Phase counter: counts 0..SETTLE-1 within LOAD and each TERM, resets to 0 on every state change.

Test Plan:
- Bench pairs the block with a behavioural datapath model (register, 3:1 operand mux, adder/sub, done gating); A..D are static.
- Reset mid-run: assert reset during TERM(C) -> outputs immediately at reset values, result=0, no result_valid. After release, start runs normally.
- Full add, SETTLE=1: A=20, B=5, C=3, D=2, op_sub=000, term_en=111, start pulse. Required response:
  - result=30 with result_valid 5 edges after accept.
  - {s2,s1} sequence 00, 01, 10 on consecutive cycles.
  - done low exactly 3 cycles.
- Mixed ops with wrap, SETTLE=2: A=10, B=20, C=200, D=7, op_sub=101, term_en=111 -> 10-20+200-7 = 183. result_valid 9 edges after accept; each TERM phase lasts 2 cycles.
- Skipped terms: A=50, B=9, C=4, D=1, op_sub=010, term_en=010 -> only the C phase runs ({s2,s1}=01, addOrSub=0); result=46 after 3 edges (SETTLE=1).
- Empty run: term_en=000, A=77 -> no TERM phase, done never low, result=77 after 2 edges.
- Handshake: pulse start again while busy -> ignored, single result_valid. Then hold start high across two runs -> second LOAD starts the cycle after the first result_valid, and results match the per-run expected values.

Source files
------------

// File: rtl/addsub_sequencer_if.sv
// rtl/addsub_sequencer_if.sv - control/handshake bundle between sequencer and add/sub datapath
interface addsub_sequencer_if;
   logic       start;
   logic [2:0] op_sub;
   logic [2:0] term_en;
   logic [7:0] acc_in;
   logic       busy;
   logic       s0;
   logic       s1;
   logic       s2;
   logic       addOrSub;
   logic       done;
   logic [7:0] result;
   logic       result_valid;

   modport master (
      output start, op_sub, term_en, acc_in,
      input  busy, s0, s1, s2, addOrSub, done, result, result_valid
   );

   modport slave (
      input  start, op_sub, term_en, acc_in,
      output busy, s0, s1, s2, addOrSub, done, result, result_valid
   );
endinterface

// File: rtl/addsub_sequencer.sv
// rtl/addsub_sequencer.sv - multicycle controller sequencing A +/- B +/- C +/- D on the datapath
// All outputs are registered from the next state, so nothing combinational reaches the datapath.
module addsub_sequencer #(
   parameter int unsigned SETTLE = 1
) (
   input logic               clock,
   input logic               reset,
   addsub_sequencer_if.slave bus
);
   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_TERM, ST_CAPTURE} state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] op_q, op_d;
   logic [2:0] en_q, en_d;
   logic [1:0] term_q, term_d;
   logic       busy_q, busy_d;
   logic       s0_q, s0_d;
   logic [1:0] sel_q, sel_d;
   logic       add_q, add_d;
   logic       done_q, done_d;
   logic [7:0] result_q, result_d;
   logic       rv_q, rv_d;

   logic       phase_end;
   logic       has_first, has_next;
   logic [1:0] first_term, next_term;

   assign phase_end = (cnt_q == 4'(SETTLE - 1));

   // Lowest enabled term overall, and lowest enabled term above the current one.
   always_comb begin
      has_first  = 1'b0;
      first_term = 2'd0;
      has_next   = 1'b0;
      next_term  = 2'd0;
      for (int i = 2; i >= 0; i--) begin
         if (en_q[i]) begin
            has_first  = 1'b1;
            first_term = 2'(i);
         end
         if (en_q[i] && (2'(i) > term_q)) begin
            has_next  = 1'b1;
            next_term = 2'(i);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      en_d     = en_q;
      term_d   = term_q;
      result_d = result_q;
      rv_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               op_d    = bus.op_sub;
               en_d    = bus.term_en;
               cnt_d   = 4'd0;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (phase_end) begin
               cnt_d = 4'd0;
               if (has_first) begin
                  term_d  = first_term;
                  state_d = ST_TERM;
               end else begin
                  state_d = ST_CAPTURE;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_TERM: begin
            if (phase_end) begin
               cnt_d = 4'd0;
               if (has_next) begin
                  term_d = next_term;
               end else begin
                  state_d = ST_CAPTURE;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_CAPTURE: begin
            result_d = bus.acc_in;
            rv_d     = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Moore outputs for the state being entered; CAPTURE keeps the last term's select.
   always_comb begin
      busy_d = (state_d != ST_IDLE);
      s0_d   = s0_q;
      sel_d  = sel_q;
      add_d  = add_q;
      done_d = done_q;
      case (state_d)
         ST_IDLE, ST_LOAD: begin
            s0_d   = 1'b0;
            sel_d  = 2'b00;
            add_d  = 1'b1;
            done_d = 1'b1;
         end
         ST_TERM: begin
            s0_d   = 1'b1;
            sel_d  = term_d;
            add_d  = ~op_d[term_d];
            done_d = 1'b0;
         end
         ST_CAPTURE: begin
            s0_d   = 1'b1;
            done_d = 1'b1;
         end
         default: begin
            s0_d   = 1'b0;
            done_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         op_q     <= 3'd0;
         en_q     <= 3'd0;
         term_q   <= 2'd0;
         busy_q   <= 1'b0;
         s0_q     <= 1'b0;
         sel_q    <= 2'b00;
         add_q    <= 1'b1;
         done_q   <= 1'b1;
         result_q <= 8'd0;
         rv_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         en_q     <= en_d;
         term_q   <= term_d;
         busy_q   <= busy_d;
         s0_q     <= s0_d;
         sel_q    <= sel_d;
         add_q    <= add_d;
         done_q   <= done_d;
         result_q <= result_d;
         rv_q     <= rv_d;
      end
   end

   assign bus.busy         = busy_q;
   assign bus.s0           = s0_q;
   assign bus.s1           = sel_q[0];
   assign bus.s2           = sel_q[1];
   assign bus.addOrSub     = add_q;
   assign bus.done         = done_q;
   assign bus.result       = result_q;
   assign bus.result_valid = rv_q;
endmodule

// File: tb/tb_addsub_sequencer.sv
// tb/tb_addsub_sequencer.sv - randomized and directed bench for addsub_sequencer
// Two instances (SETTLE=1 and SETTLE=2) each drive their own behavioural datapath model.
module tb_addsub_sequencer;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [2:0] op_sub = 3'd0;
   logic [2:0] term_en = 3'd0;
   logic [7:0] av = 8'd0, bv = 8'd0, cv = 8'd0, dv = 8'd0;
   logic [7:0] acc1, acc2;
   logic [2:0] key1, key2;
   bit         dsel = 1'b0;
   int         n_chk = 0;
   int         n_fail = 0;

   always #5 clock = ~clock;

   addsub_sequencer_if if1();
   addsub_sequencer_if if2();

   assign if1.start   = start;
   assign if1.op_sub  = op_sub;
   assign if1.term_en = term_en;
   assign if1.acc_in  = acc1;
   assign if2.start   = start;
   assign if2.op_sub  = op_sub;
   assign if2.term_en = term_en;
   assign if2.acc_in  = acc2;

   addsub_sequencer #(.SETTLE(1)) u_dut1 (.clock(clock), .reset(reset), .bus(if1.slave));
   addsub_sequencer #(.SETTLE(2)) u_dut2 (.clock(clock), .reset(reset), .bus(if2.slave));

   logic       o_busy, o_s0, o_s1, o_s2, o_add, o_done, o_rv;
   logic [7:0] o_result;
   assign o_busy   = dsel ? if2.busy         : if1.busy;
   assign o_s0     = dsel ? if2.s0           : if1.s0;
   assign o_s1     = dsel ? if2.s1           : if1.s1;
   assign o_s2     = dsel ? if2.s2           : if1.s2;
   assign o_add    = dsel ? if2.addOrSub     : if1.addOrSub;
   assign o_done   = dsel ? if2.done         : if1.done;
   assign o_rv     = dsel ? if2.result_valid : if1.result_valid;
   assign o_result = dsel ? if2.result       : if1.result;

   // Datapath: s0=0 loads A; an operand is applied once whenever a new unfrozen term appears.
   function automatic logic [7:0] dp_step(input logic [7:0] acc, input logic s2, input logic s1,
                                          input logic add);
      logic [7:0] opnd;
      opnd = s2 ? dv : (s1 ? cv : bv);
      return add ? acc + opnd : acc - opnd;
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         acc1 <= 8'd0; key1 <= 3'b100;
         acc2 <= 8'd0; key2 <= 3'b100;
      end else begin
         key1 <= {if1.done, if1.s2, if1.s1};
         key2 <= {if2.done, if2.s2, if2.s1};
         if (!if1.s0) acc1 <= av;
         else if (!if1.done && ({if1.done, if1.s2, if1.s1} != key1))
            acc1 <= dp_step(acc1, if1.s2, if1.s1, if1.addOrSub);
         if (!if2.s0) acc2 <= av;
         else if (!if2.done && ({if2.done, if2.s2, if2.s1} != key2))
            acc2 <= dp_step(acc2, if2.s2, if2.s1, if2.addOrSub);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_busy"}, o_busy, 1'b0);
      chk({tag, "_s0"}, o_s0, 1'b0);
      chk({tag, "_sel"}, {o_s2, o_s1}, 2'b00);
      chk({tag, "_add"}, o_add, 1'b1);
      chk({tag, "_done"}, o_done, 1'b1);
      chk({tag, "_rv"}, o_rv, 1'b0);
   endtask

   // Expects to be entered at a negedge; start is raised so the next posedge accepts.
   task automatic run_one(input bit ds, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d, input logic [2:0] op,
                          input logic [2:0] en, input bit hold, input int pulse_at,
                          input int fix);
      int         s, n, lat, dlow, pa;
      logic [7:0] r;
      logic [7:0] v [3];
      logic [1:0] tl [$];
      logic [1:0] t;
      dsel = ds;
      s = ds ? 2 : 1;
      av = a; bv = b; cv = c; dv = d;
      op_sub = op; term_en = en; start = 1'b1;
      v[0] = b; v[1] = c; v[2] = d;
      r = a;
      tl = {};
      for (int i = 0; i < 3; i++) begin
         if (en[i]) begin
            tl.push_back(2'(i));
            r = op[i] ? r - v[i] : r + v[i];
         end
      end
      n = tl.size();
      lat = s * (1 + n) + 1;
      pa = (pulse_at >= lat) ? lat - 1 : pulse_at;
      dlow = 0;
      @(posedge clock);
      for (int k = 0; k <= lat; k++) begin
         @(negedge clock);
         if (k < lat) begin
            chk("busy", o_busy, 1'b1);
            chk("rv_early", o_rv, 1'b0);
            if (k < s) begin
               chk("load_s0", o_s0, 1'b0);
               chk("load_done", o_done, 1'b1);
            end else if (k < s + s * n) begin
               t = tl[(k - s) / s];
               chk("term_s0", o_s0, 1'b1);
               chk("term_done", o_done, 1'b0);
               chk("term_sel", {o_s2, o_s1}, t);
               chk("term_add", o_add, !op[t]);
            end else begin
               chk("cap_s0", o_s0, 1'b1);
               chk("cap_done", o_done, 1'b1);
               if (n > 0) begin
                  chk("cap_sel", {o_s2, o_s1}, tl[n - 1]);
                  chk("cap_add", o_add, !op[tl[n - 1]]);
               end
            end
         end else begin
            chk("rv", o_rv, 1'b1);
            chk("result", o_result, r);
            if (fix >= 0) chk("result_fixed", o_result, fix[7:0]);
            chk("idle_busy", o_busy, 1'b0);
            chk("idle_s0", o_s0, 1'b0);
            chk("idle_sel", {o_s2, o_s1}, 2'b00);
            chk("idle_add", o_add, 1'b1);
            chk("idle_done", o_done, 1'b1);
         end
         if (!o_done) dlow++;
         if (k == 0 && !hold) start = 1'b0;
         if (k == 1) begin
            op_sub = 3'($urandom);
            term_en = 3'($urandom);
         end
         if (pa > 0 && !hold) start = (k == pa);
      end
      chk("done_low_cycles", dlow, s * n);
   endtask

   task automatic settle();
      int extra, w;
      extra = 0;
      w = 0;
      start = 1'b0;
      while ((if1.busy || if2.busy) && w < 60) begin
         @(negedge clock);
         if (o_rv) extra++;
         w++;
      end
      if (w >= 60) chk("idle_timeout", 1'b0, 1'b1);
      repeat (3) begin
         @(negedge clock);
         if (o_rv) extra++;
      end
      chk("extra_rv", extra, 0);
   endtask

   initial begin
      repeat (3) @(negedge clock);
      for (int i = 0; i < 2; i++) begin
         dsel = bit'(i);
         #1;
         chk_idle_outputs("reset");
         chk("reset_result", o_result, 8'd0);
      end
      reset = 1'b0;
      @(negedge clock);

      // Directed cases
      run_one(1'b0, 8'd20, 8'd5, 8'd3, 8'd2, 3'b000, 3'b111, 1'b0, 0, 30);
      settle();
      run_one(1'b1, 8'd10, 8'd20, 8'd200, 8'd7, 3'b101, 3'b111, 1'b0, 0, 183);
      settle();
      run_one(1'b0, 8'd50, 8'd9, 8'd4, 8'd1, 3'b010, 3'b010, 1'b0, 0, 46);
      settle();
      run_one(1'b0, 8'd77, 8'd1, 8'd2, 8'd3, 3'b000, 3'b000, 1'b0, 0, 77);
      settle();

      // Start pulsed while busy must be ignored
      run_one(1'b0, 8'd1, 8'd2, 8'd3, 8'd4, 3'b000, 3'b111, 1'b0, 2, 10);
      settle();

      // Start held high: second run accepted on the edge after the first result_valid
      run_one(1'b0, 8'd100, 8'd10, 8'd20, 8'd30, 3'b111, 3'b111, 1'b1, 0, 40);
      run_one(1'b0, 8'd5, 8'd250, 8'd0, 8'd9, 3'b000, 3'b101, 1'b0, 0, 8);
      settle();

      // Reset asserted during TERM(C) aborts the run
      dsel = 1'b0;
      av = 8'd9; bv = 8'd8; cv = 8'd7; dv = 8'd6;
      op_sub = 3'b000; term_en = 3'b111; start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      repeat (2) @(negedge clock);
      chk("pre_reset_sel_c", {o_s2, o_s1}, 2'b01);
      reset = 1'b1;
      #1;
      chk_idle_outputs("midrun_reset");
      chk("midrun_reset_result", o_result, 8'd0);
      @(negedge clock);
      reset = 1'b0;
      settle();

      // Randomized runs on both instances
      for (int i = 0; i < 12; i++) begin
         run_one(bit'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
                 8'($urandom), 3'($urandom), 3'($urandom), 1'b0,
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : 0, -1);
         settle();
      end
      for (int i = 0; i < 3; i++) begin
         run_one(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 3'($urandom), 3'($urandom), 1'b1, 0, -1);
      end
      run_one(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              3'($urandom), 3'($urandom), 1'b0, 0, -1);
      settle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
